// File: rtl/sap_control_sequencer.sv
// sap_control_sequencer: six-state ring-counter controller that decodes the IR opcode into per-T-state control words.
module sap_control_sequencer #(
    parameter int NUM_T    = 6,
    parameter int OPCODE_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic [OPCODE_W-1:0] opcode,
    output logic [NUM_T-1:0]    t_state,
    output logic                clr_n,
    output logic                cp,
    output logic                ep,
    output logic                lp,
    output logic                lm,
    output logic                ce,
    output logic                li,
    output logic                ei,
    output logic                la,
    output logic                ea,
    output logic                lb,
    output logic                su,
    output logic                eu,
    output logic                lo,
    output logic                halted
);

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } t_state_e;

    localparam logic [OPCODE_W-1:0] OP_LDA = 4'b0000;
    localparam logic [OPCODE_W-1:0] OP_ADD = 4'b0001;
    localparam logic [OPCODE_W-1:0] OP_SUB = 4'b0010;
    localparam logic [OPCODE_W-1:0] OP_JMP = 4'b0011;
    localparam logic [OPCODE_W-1:0] OP_OUT = 4'b1110;
    localparam logic [OPCODE_W-1:0] OP_HLT = 4'b1111;

    t_state_e state_q, state_d;
    logic     halted_q, halted_d;
    logic     clr_n_q;

    // State register; clr_n is held low only for the cycles rst is seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= T1;
            halted_q <= 1'b0;
            clr_n_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
            clr_n_q  <= 1'b1;
        end
    end

    // Advance the ring while running; a HLT in T4 freezes the ring at T4 instead of advancing.
    always_comb begin
        state_d  = state_q;
        halted_d = halted_q;
        if (run && !halted_q) begin
            if (state_q == T4 && opcode == OP_HLT)
                halted_d = 1'b1;
            else
                state_d = t_state_e'({state_q[4:0], state_q[5]});
        end
    end

    logic en, t1, t2, t3, t4, t5, t6;
    logic is_lda, is_add, is_sub, is_jmp, is_out, mem_op;

    assign en     = run && !halted_q && !rst;
    assign {t6, t5, t4, t3, t2, t1} = state_q;
    assign is_lda = opcode == OP_LDA;
    assign is_add = opcode == OP_ADD;
    assign is_sub = opcode == OP_SUB;
    assign is_jmp = opcode == OP_JMP;
    assign is_out = opcode == OP_OUT;
    assign mem_op = is_lda || is_add || is_sub;

    assign t_state = state_q;
    assign halted  = halted_q;
    assign clr_n   = clr_n_q;
    assign ep      = en && t1;
    assign lm      = en && (t1 || (t4 && mem_op));
    assign cp      = en && t2;
    assign ce      = en && (t3 || (t5 && mem_op));
    assign li      = en && t3;
    assign ei      = en && t4 && (mem_op || is_jmp);
    assign lp      = en && t4 && is_jmp;
    assign ea      = en && t4 && is_out;
    assign lo      = en && t4 && is_out;
    assign la      = en && ((t5 && is_lda) || (t6 && (is_add || is_sub)));
    assign lb      = en && t5 && (is_add || is_sub);
    assign eu      = en && t6 && (is_add || is_sub);
    assign su      = en && t6 && is_sub;

endmodule

// File: tb/tb_sap_control_sequencer.sv
// tb_sap_control_sequencer: directed checks of ring counter, fetch/execute decode, stall, halt and reset.
module tb_sap_control_sequencer;

    logic       clk = 1'b0;
    logic       rst, run;
    logic [3:0] opcode;
    logic [5:0] t_state;
    logic       clr_n, cp, ep, lp, lm, ce, li, ei, la, ea, lb, su, eu, lo, halted;

    int total = 0;
    int bad   = 0;

    localparam logic [12:0] CP = 13'h1000, EP = 13'h0800, LP = 13'h0400, LM = 13'h0200,
                            CE = 13'h0100, LI = 13'h0080, EI = 13'h0040, LA = 13'h0020,
                            EA = 13'h0010, LB = 13'h0008, SU = 13'h0004, EU = 13'h0002,
                            LO = 13'h0001, NONE = 13'h0000;

    logic [12:0] cw;
    assign cw = {cp, ep, lp, lm, ce, li, ei, la, ea, lb, su, eu, lo};

    sap_control_sequencer dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode), .t_state(t_state),
        .clr_n(clr_n), .cp(cp), .ep(ep), .lp(lp), .lm(lm), .ce(ce), .li(li),
        .ei(ei), .la(la), .ea(ea), .lb(lb), .su(su), .eu(eu), .lo(lo), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic chk_st(input string tag, input logic [5:0] t, input logic [12:0] c);
        #1;
        chk({tag, "_t"}, {10'd0, t_state}, {10'd0, t});
        chk({tag, "_cw"}, {3'd0, cw}, {3'd0, c});
    endtask

    initial begin
        rst = 1'b1; run = 1'b1; opcode = 4'b0000;
        tick(); tick();
        chk_st("rst", 6'h01, NONE);
        chk("rst_halt", {15'd0, halted}, 16'd0);
        chk("rst_clrn", {15'd0, clr_n}, 16'd0);
        rst = 1'b0;
        chk_st("lda_t1", 6'h01, EP | LM);
        chk("clrn_pre", {15'd0, clr_n}, 16'd0);
        tick(); chk_st("lda_t2", 6'h02, CP);
        chk("clrn_post", {15'd0, clr_n}, 16'd1);
        tick(); chk_st("lda_t3", 6'h04, CE | LI);
        tick(); chk_st("lda_t4", 6'h08, EI | LM);
        tick(); chk_st("lda_t5", 6'h10, CE | LA);
        tick(); chk_st("lda_t6", 6'h20, NONE);
        tick(); chk_st("wrap_t1", 6'h01, EP | LM);
        opcode = 4'b0001;
        tick(); tick(); tick(); chk_st("add_t4", 6'h08, EI | LM);
        tick(); chk_st("add_t5", 6'h10, CE | LB);
        tick(); chk_st("add_t6", 6'h20, EU | LA);
        tick(); opcode = 4'b0010;
        tick(); chk_st("sub_t2", 6'h02, CP);
        tick(); tick(); chk_st("sub_t4", 6'h08, EI | LM);
        tick(); chk_st("sub_t5", 6'h10, CE | LB);
        tick(); chk_st("sub_t6", 6'h20, SU | EU | LA);
        tick(); opcode = 4'b0011;
        tick(); chk_st("jmp_t2", 6'h02, CP);
        tick(); tick(); chk_st("jmp_t4", 6'h08, EI | LP);
        tick(); chk_st("jmp_t5", 6'h10, NONE);
        tick(); chk_st("jmp_t6", 6'h20, NONE);
        tick(); opcode = 4'b1110;
        tick(); tick(); tick(); chk_st("out_t4", 6'h08, EA | LO);
        tick(); tick(); tick(); opcode = 4'b0000;
        chk_st("out_wrap", 6'h01, EP | LM);
        tick(); tick(); chk_st("stall_t3", 6'h04, CE | LI);
        run = 1'b0;
        chk_st("stall_0", 6'h04, NONE);
        for (int i = 0; i < 3; i++) begin
            tick(); chk_st("stall_hold", 6'h04, NONE);
        end
        run = 1'b1;
        chk_st("resume_t3", 6'h04, CE | LI);
        tick(); chk_st("resume_t4", 6'h08, EI | LM);
        opcode = 4'b0001;
        tick(); chk_st("add2_t5", 6'h10, CE | LB);
        rst = 1'b1;
        chk_st("rst_mid_cw", 6'h10, NONE);
        tick(); chk_st("rst_mid", 6'h01, NONE);
        chk("rst_mid_clrn", {15'd0, clr_n}, 16'd0);
        rst = 1'b0;
        tick(); chk_st("post_rst_t2", 6'h02, CP);
        chk("post_rst_clrn", {15'd0, clr_n}, 16'd1);
        opcode = 4'b0101;
        tick(); chk_st("nop_t3", 6'h04, CE | LI);
        tick(); chk_st("nop_t4", 6'h08, NONE);
        tick(); chk_st("nop_t5", 6'h10, NONE);
        tick(); chk_st("nop_t6", 6'h20, NONE);
        tick(); chk_st("nop_wrap", 6'h01, EP | LM);
        opcode = 4'b1111;
        tick(); tick(); tick(); chk_st("hlt_t4", 6'h08, NONE);
        chk("hlt_pre", {15'd0, halted}, 16'd0);
        for (int i = 0; i < 11; i++) begin
            tick(); chk_st("hlt_hold", 6'h08, NONE);
            chk("hlt_flag", {15'd0, halted}, 16'd1);
        end
        opcode = 4'b0000;
        tick(); chk_st("hlt_sticky", 6'h08, NONE);
        rst = 1'b1;
        tick(); chk_st("hlt_rst", 6'h01, NONE);
        chk("hlt_rst_flag", {15'd0, halted}, 16'd0);
        rst = 1'b0;
        tick(); chk_st("hlt_rst_run", 6'h02, CP);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
